// File: rtl/fpu_pkg.sv
// Shared floating-point definitions for the integer-to-float converter.
//   rm_e              : RISC-V rounding-mode encoding (RM_RNE..RM_RMM)
//   FLAG_*            : bit positions inside the {NV,DZ,OF,UF,NX} fflags vector
//   mant_w/exp_w/bias : IEEE-754 field sizes for a 32-bit (single) or
//                       64-bit (double) result, selected by bus width
package fpu_pkg;

  typedef enum logic [2:0] {
    RM_RNE = 3'd0,
    RM_RTZ = 3'd1,
    RM_RDN = 3'd2,
    RM_RUP = 3'd3,
    RM_RMM = 3'd4
  } rm_e;

  localparam int FLAG_NX = 0;
  localparam int FLAG_UF = 1;
  localparam int FLAG_OF = 2;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_NV = 4;

  function automatic int mant_w(input int bw);
    return (bw == 32) ? 23 : 52;
  endfunction

  function automatic int exp_w(input int bw);
    return (bw == 32) ? 8 : 11;
  endfunction

  function automatic int bias(input int bw);
    return (bw == 32) ? 127 : 1023;
  endfunction

endpackage

// File: rtl/lead_one_det.sv
// Combinational leading-one detector.
//   vec   : input vector
//   idx   : bit position of the highest set bit of vec (0 when vec is zero)
//   found : vec has at least one bit set
module lead_one_det #(
  parameter int W = 64,
  localparam int IW = $clog2(W)
) (
  input  logic [W-1:0]  vec,
  output logic [IW-1:0] idx,
  output logic          found
);

  // Scan upward so the last (highest) set bit wins.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (vec[i]) begin
        idx   = IW'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fcvt_i2f_pipe.sv
// Three-stage integer to IEEE-754 converter (int32->single or int64->double).
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   : operand handshake; in_ready is low during flush
//   in_data             : integer operand
//   in_unsigned         : 1 = unsigned operand, 0 = two's complement
//   in_rm               : rounding mode (codes 5-7 behave as RNE)
//   flush               : drop every operation in flight
//   out_valid/out_ready : result handshake; result held while stalled
//   out_data            : packed float, reads 0 whenever out_valid is 0
//   out_flags           : {NV,DZ,OF,UF,NX}, only when FCVT_I2F_FLAGS_EN is defined
// Optional feature macro: FCVT_I2F_FLAGS_EN (adds out_flags and NX generation).
module fcvt_i2f_pipe
  import fpu_pkg::*;
#(
  parameter int BUS_WIDTH = 64,
  parameter int FLAG_W    = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BUS_WIDTH-1:0] in_data,
  input  logic                 in_unsigned,
  input  logic [2:0]           in_rm,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BUS_WIDTH-1:0] out_data
`ifdef FCVT_I2F_FLAGS_EN
  ,
  output logic [FLAG_W-1:0]    out_flags
`endif
);

  localparam int MANT = mant_w(BUS_WIDTH);
  localparam int EXP  = exp_w(BUS_WIDTH);
  localparam int BIAS = bias(BUS_WIDTH);
  localparam int IW   = $clog2(BUS_WIDTH);

  function automatic logic round_inc(input logic [2:0] rm, input logic sign,
                                     input logic lsb, input logic g, input logic s);
    logic inc;
    case (rm)
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = sign && (g || s);
      RM_RUP:  inc = !sign && (g || s);
      RM_RMM:  inc = g;
      default: inc = g && (s || lsb);
    endcase
    return inc;
  endfunction

  logic                 vld_p0, vld_p1, vld_p2;
  logic                 adv, take;

  logic                 sign_in;
  logic [BUS_WIDTH-1:0] mag_in;

  logic                 sign_p0;
  logic [2:0]           rm_p0;
  logic [BUS_WIDTH-1:0] mag_p0;

  logic [IW-1:0]        lo_idx;
  logic                 lo_found;
  logic [IW:0]          sh;
  logic [BUS_WIDTH-1:0] norm_c;
  logic [EXP-1:0]       exp_c;

  logic                 sign_p1, zero_p1;
  logic [2:0]           rm_p1;
  logic [BUS_WIDTH-1:0] norm_p1;
  logic [EXP-1:0]       exp_p1;

  logic [MANT-1:0]      frac_c;
  logic                 g_c, s_c, inc_c;
  logic [MANT:0]        sum_c;
  logic [EXP-1:0]       exp_r;
  logic [BUS_WIDTH-1:0] packed_c;

  logic [BUS_WIDTH-1:0] data_p2;

  // Every stage moves whenever the output register is empty or being drained.
  assign adv      = !vld_p2 || out_ready;
  assign in_ready = adv && !flush;
  assign take     = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else if (flush) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else if (adv) begin
      vld_p0 <= take;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
    end
  end

  // ---- S1: sign and absolute value ----
  assign sign_in = in_data[BUS_WIDTH-1] && !in_unsigned;
  assign mag_in  = sign_in ? -in_data : in_data;

  always_ff @(posedge clk) begin
    if (adv) begin
      sign_p0 <= sign_in;
      rm_p0   <= in_rm;
      mag_p0  <= mag_in;
    end
  end

  // ---- S2: leading-one index and normalising shift ----
  lead_one_det #(.W(BUS_WIDTH)) u_lod (
    .vec   (mag_p0),
    .idx   (lo_idx),
    .found (lo_found)
  );

  // Shift one past the leading one so it falls off the top; the register then
  // holds exactly the fraction, guard and sticky bits.
  assign sh     = (IW+1)'(BUS_WIDTH) - {1'b0, lo_idx};
  assign norm_c = mag_p0 << sh;
  assign exp_c  = EXP'(BIAS) + EXP'(lo_idx);

  always_ff @(posedge clk) begin
    if (adv) begin
      sign_p1 <= sign_p0;
      zero_p1 <= !lo_found;
      rm_p1   <= rm_p0;
      norm_p1 <= norm_c;
      exp_p1  <= exp_c;
    end
  end

  // ---- S3: round, renormalise, pack ----
  assign frac_c = norm_p1[BUS_WIDTH-1 -: MANT];
  assign g_c    = norm_p1[BUS_WIDTH-1-MANT];
  assign s_c    = |norm_p1[BUS_WIDTH-2-MANT:0];
  assign inc_c  = round_inc(rm_p1, sign_p1, frac_c[0], g_c, s_c);
  assign sum_c  = {1'b0, frac_c} + {{MANT{1'b0}}, inc_c};
  // A carry out leaves the low fraction bits all zero, so only the exponent moves.
  assign exp_r  = exp_p1 + EXP'(sum_c[MANT]);
  assign packed_c = zero_p1 ? '0 : {sign_p1, exp_r, sum_c[MANT-1:0]};

  always_ff @(posedge clk) begin
    if (adv) begin
      data_p2 <= packed_c;
    end
  end

  assign out_valid = vld_p2;
  assign out_data  = vld_p2 ? data_p2 : '0;

`ifdef FCVT_I2F_FLAGS_EN
  logic [FLAG_W-1:0] flags_p2;

  always_ff @(posedge clk) begin
    if (adv) begin
      flags_p2          <= '0;
      flags_p2[FLAG_NX] <= g_c || s_c;
    end
  end

  assign out_flags = vld_p2 ? flags_p2 : '0;
`endif

endmodule

// File: tb/tb_fcvt_i2f_pipe.sv
module tb_fcvt_i2f_pipe;

  localparam int BW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [BW-1:0] in_data = '0;
  logic          in_unsigned = 1'b0;
  logic [2:0]    in_rm = 3'd0;
  logic          flush = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [BW-1:0] out_data;
`ifdef FCVT_I2F_FLAGS_EN
  logic [4:0]    out_flags;
`endif

  fcvt_i2f_pipe #(.BUS_WIDTH(BW), .FLAG_W(5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_unsigned (in_unsigned),
    .in_rm       (in_rm),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data)
`ifdef FCVT_I2F_FLAGS_EN
    ,
    .out_flags   (out_flags)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        u;
    logic [2:0]  rm;
    logic [31:0] e;
    logic        nx;
  } vec_t;

  vec_t vt[18];
  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Offer one operand, then wait (bounded) for its result and compare it.
  task automatic run_vec(input int k, input bit chk_lat);
    int  w;
    bit  got;
    @(negedge clk);
    in_valid = 1'b1; in_data = vt[k].d; in_unsigned = vt[k].u; in_rm = vt[k].rm;
    out_ready = 1'b1;
    #1 check($sformatf("vec%0d_in_ready", k), 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    got = 1'b0;
    w = 0;
    while (w < 10 && !got) begin
      #1;
      if (out_valid) got = 1'b1;
      else begin
        @(negedge clk);
        w++;
      end
    end
    if (!got) check($sformatf("vec%0d_timeout", k), 32'd0, 32'd1);
    else begin
      check($sformatf("vec%0d_data", k), out_data, vt[k].e);
`ifdef FCVT_I2F_FLAGS_EN
      check($sformatf("vec%0d_flags", k), 32'(out_flags), {27'd0, 4'd0, vt[k].nx});
`endif
      if (chk_lat) check("latency", w, 32'd2);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [31:0] rx[$];
    logic [31:0] exp6[6];
    logic [31:0] prev;
    bit          prev_stall;
    bit          saw_stall;
    int          sent;

    vt[0]  = '{32'h00000001, 1'b0, 3'd0, 32'h3F800000, 1'b0};
    vt[1]  = '{32'hFFFFFFFF, 1'b0, 3'd0, 32'hBF800000, 1'b0};
    vt[2]  = '{32'h00000000, 1'b0, 3'd0, 32'h00000000, 1'b0};
    vt[3]  = '{32'h7FFFFFFF, 1'b0, 3'd0, 32'h4F000000, 1'b1};
    vt[4]  = '{32'h7FFFFFFF, 1'b0, 3'd1, 32'h4EFFFFFF, 1'b1};
    vt[5]  = '{32'h80000000, 1'b0, 3'd0, 32'hCF000000, 1'b0};
    vt[6]  = '{32'hFFFFFFFF, 1'b1, 3'd0, 32'h4F800000, 1'b1};
    vt[7]  = '{32'hFFFFFFFF, 1'b1, 3'd2, 32'h4F7FFFFF, 1'b1};
    vt[8]  = '{32'h00000003, 1'b0, 3'd0, 32'h40400000, 1'b0};
    vt[9]  = '{32'h01000001, 1'b0, 3'd0, 32'h4B800000, 1'b1};
    vt[10] = '{32'h01000001, 1'b0, 3'd3, 32'h4B800001, 1'b1};
    vt[11] = '{32'h01000001, 1'b0, 3'd4, 32'h4B800001, 1'b1};
    vt[12] = '{32'h01000001, 1'b0, 3'd7, 32'h4B800000, 1'b1};
    vt[13] = '{32'h01000003, 1'b0, 3'd0, 32'h4B800002, 1'b1};
    vt[14] = '{32'hFEFFFFFF, 1'b0, 3'd2, 32'hCB800001, 1'b1};
    vt[15] = '{32'hFEFFFFFF, 1'b0, 3'd1, 32'hCB800000, 1'b1};
    vt[16] = '{32'h00000000, 1'b0, 3'd3, 32'h00000000, 1'b0};
    vt[17] = '{32'h80000000, 1'b1, 3'd0, 32'h4F000000, 1'b0};

    exp6 = '{32'h3F800000, 32'h40000000, 32'h40400000,
             32'h40800000, 32'h40A00000, 32'h40C00000};

    // Reset state
    #1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_data", out_data, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1 check("release_in_ready", 32'(in_ready), 32'd1);

    // Directed vector table
    for (int k = 0; k < 18; k++) run_vec(k, k == 0);

    // Backpressure: out_ready low on stream cycles 4-8
    sent = 0; saw_stall = 1'b0; prev_stall = 1'b0; prev = '0;
    for (int c = 1; c <= 40 && rx.size() < 6; c++) begin
      @(negedge clk);
      out_ready   = !(c >= 4 && c <= 8);
      in_valid    = (sent < 6);
      in_data     = 32'(sent + 1);
      in_unsigned = 1'b0;
      in_rm       = 3'd0;
      #1;
      if (prev_stall) check($sformatf("bp_hold_c%0d", c), out_data, prev);
      prev_stall = out_valid && !out_ready;
      prev = out_data;
      if (in_valid && !in_ready) saw_stall = 1'b1;
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) rx.push_back(out_data);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("bp_in_ready_fell", 32'(saw_stall), 32'd1);
    check("bp_count", 32'(rx.size()), 32'd6);
    for (int i = 0; i < 6; i++)
      check($sformatf("bp_order%0d", i), (i < rx.size()) ? rx[i] : 32'hDEADBEEF, exp6[i]);
    repeat (3) begin
      @(negedge clk);
      #1 check("bp_no_extra", 32'(out_valid), 32'd0);
    end

    // Flush with three operations in flight
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 32'(10 + c); in_rm = 3'd0; out_ready = 1'b0;
    end
    @(negedge clk);
    in_data = 32'd13; flush = 1'b1;
    #1;
    check("flush_in_ready", 32'(in_ready), 32'd0);
    check("flush_s3_full", 32'(out_valid), 32'd1);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1 check("flush_next_cycle", 32'(out_valid), 32'd0);
    repeat (3) begin
      @(negedge clk);
      #1 check("flush_stays_empty", 32'(out_valid), 32'd0);
    end
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'd7;
    #1 check("postflush_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1 check("postflush_lat1", 32'(out_valid), 32'd0);
    @(negedge clk);
    #1 check("postflush_lat2", 32'(out_valid), 32'd0);
    @(negedge clk);
    #1;
    check("postflush_lat3", 32'(out_valid), 32'd1);
    check("postflush_data", out_data, 32'h40E00000);

    // Reset in the middle of a stalled stream
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 32'(5 + c); out_ready = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1 check("prereset_valid", 32'(out_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_valid", 32'(out_valid), 32'd0);
    check("async_reset_data", out_data, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1 check("rerelease_in_ready", 32'(in_ready), 32'd1);
    run_vec(0, 1'b1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/fcvt_i2f_pipe.md
FCVT_I2F_PIPE -- requirements
Module: fcvt_i2f_pipe

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 64, meaning integer input and float output width; legal values are 32 (int to single) and 64 (int to double).
REQ-002 SHALL have parameter FLAG_W, default 5, meaning width of the RISC-V fflags vector {NV,DZ,OF,UF,NX}.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: an input operand is offered.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts the operand this cycle.
REQ-007 SHALL have port in_data, input, BUS_WIDTH bits: integer operand.
REQ-008 SHALL have port in_unsigned, input, 1 bit: 1 treats in_data as unsigned, 0 as two's complement.
REQ-009 SHALL have port in_rm, input, 3 bits: rounding mode (0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM).
REQ-010 SHALL have port flush, input, 1 bit: discard all in-flight operations.
REQ-011 SHALL have port out_valid, output, 1 bit: a result is presented.
REQ-012 SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-013 SHALL have port out_data, output, BUS_WIDTH bits: IEEE-754 result.
REQ-014 SHALL have port out_flags, output, FLAG_W bits: exception flags (present only under REQ-030).

Function
REQ-015 SHALL be a 3-stage pipeline: S1 sign/absolute value; S2 leading-one index plus normalising left shift; S3 round, renormalise, pack.
REQ-016 SHALL take 3 cycles from the in_valid&&in_ready edge to out_valid, and SHALL sustain 1 result/cycle when out_ready is held at 1.
REQ-017 SHALL drive in_ready = !S3_valid || out_ready, so that all stages advance together and hold together.
REQ-018 SHALL keep out_data/out_flags stable while out_valid && !out_ready.
REQ-019 SHALL take the sign as in_data[MSB] && !in_unsigned; magnitude = sign ? -in_data : in_data, held in BUS_WIDTH bits unsigned; the most negative value yields magnitude 2^(BUS_WIDTH-1).
REQ-020 SHALL compute exponent = index + BIAS and fraction = the MANT bits below the leading one; G = the next bit, S = OR of all remaining bits.
REQ-021 SHALL round as follows: RNE increments on G&&(S||lsb); RTZ never; RDN on sign&&(G||S); RUP on !sign&&(G||S); RMM on G.
REQ-022 SHALL, on fraction carry-out from rounding, clear the fraction and increment the exponent by 1; overflow to infinity is unreachable.
REQ-023 SHALL produce +0 (all zeros) for input zero, with no flags, in every rounding mode.
REQ-024 SHALL treat in_rm values 5-7 as RNE, with no flag raised.
REQ-025 SHALL, on flush, clear all stage valid bits at the next edge; in that cycle flush takes priority over accepting input, and in_ready is 0 while flush=1.

Reset
REQ-026 SHALL, while rst_n=0, immediately (asynchronously) clear all stage valid bits, so out_valid=0, out_data=0, out_flags=0.
REQ-027 SHALL drive in_ready=1 in the first cycle after reset release; an operation in flight at reset assertion is lost with no output.
REQ-028 Datapath registers other than the valid bits need no reset; out_data SHALL nonetheless read 0 whenever out_valid=0.

Configuration
REQ-029 SHALL be controlled by the macro FCVT_I2F_FLAGS_EN.
REQ-030 With FCVT_I2F_FLAGS_EN defined, out_flags SHALL exist, with NX = G||S on the accepted operand and NV/DZ/OF/UF = 0.
REQ-031 Without FCVT_I2F_FLAGS_EN, the out_flags port and all G/S-to-NX logic SHALL be absent; out_data SHALL be identical in both builds.

Structure
REQ-032 Package fpu_pkg SHALL hold the rounding-mode enum (RM_RNE..RM_RMM), flag bit indices, and per-width MANT/EXP/BIAS constants selected by BUS_WIDTH.
REQ-033 Sub-module lead_one_det (parametrised by width, combinational, output index of the highest set bit) SHALL be instantiated in S2.

Verification
REQ-034 BUS_WIDTH=32, signed, RNE: in 1 -> 0x3F800000; in 0xFFFFFFFF -> 0xBF800000; in 0 -> 0x00000000, NX=0.
REQ-035 BUS_WIDTH=32, signed: 0x7FFFFFFF with RNE -> 0x4F000000, NX=1; with RTZ -> 0x4EFFFFFF, NX=1; 0x80000000 -> 0xCF000000, NX=0.
REQ-036 BUS_WIDTH=32, unsigned, 0xFFFFFFFF: RNE -> 0x4F800000 (carry-out exponent bump); RDN -> 0x4F7FFFFF.
REQ-037 Backpressure: stream 6 operands with out_ready=0 on cycles 4-8 -> in_ready falls once S3 is full, no result is lost or duplicated, and order is preserved.
REQ-038 Flush with 3 operations in flight -> out_valid=0 from the next cycle, and the next accepted operand appears 3 cycles after acceptance.
REQ-039 Reset asserted mid-stream -> out_valid drops asynchronously, and after release the first result corresponds to the first new operand.
